// File: rtl/pulse_seq_pkg.sv
// Shared types and sizing helpers for the pulse sequencer.
package pulse_seq_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } pulse_seq_state_t;

  // Index width for a table of 'depth' entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adder_n.sv
// Plain N-bit adder; carry-out is dropped.
module adder_n #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/comparator_eq.sv
// N-bit equality comparator.
module comparator_eq #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/step_timer.sv
// Per-step tick counter: counts enabled cycles from 1 up to the step period.
// A period of 0 is treated as 1 so every step lasts at least one cycle.
module step_timer #(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ena_i,
  input  logic         load_i,
  input  logic [N-1:0] ticks_i,
  output logic         match_o
);

  logic [N-1:0] count_q, count_d;
  logic [N-1:0] eff_ticks;
  logic [N-1:0] count_inc;
  logic         match;

  assign eff_ticks = (ticks_i == '0) ? N'(1) : ticks_i;

  adder_n #(.W(N)) u_inc (
    .a_i   (count_q),
    .b_i   (N'(1)),
    .sum_o (count_inc)
  );

  comparator_eq #(.W(N)) u_cmp (
    .a_i  (count_q),
    .b_i  (eff_ticks),
    .eq_o (match)
  );

  // Holding at the match value keeps count from ever passing eff_ticks.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = N'(1);
    end else if (ena_i && !match) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= N'(1);
    end else begin
      count_q <= count_d;
    end
  end

  assign match_o = match;

endmodule

// File: rtl/pulse_sequencer.sv
// Plays back a small table of tick periods, one pulse per step, for a set
// number of passes or until stopped.
//
//   state  | meaning
//   S_IDLE | waiting for start; timer held at 1, step held at 0
//   S_RUN  | stepping through table[0..last_idx], pass after pass
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ena_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [N-1:0]             wr_ticks_i,
  input  logic [$clog2(DEPTH)-1:0] last_idx_i,
  input  logic [REP_W-1:0]         repeats_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH)-1:0] step_o,
  output logic                     pulse_o,
  output logic                     done_o
);

  localparam int unsigned IW = idx_w(DEPTH);

  pulse_seq_state_t state_q, state_d;
  logic [IW-1:0]    step_q, step_d;
  logic [IW-1:0]    step_inc;
  logic [IW-1:0]    last_idx_q, last_idx_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [REP_W-1:0] pass_inc;
  logic [REP_W-1:0] repeats_q, repeats_d;
  logic [N-1:0]     cur_ticks_q, cur_ticks_d;
  logic             done_q, done_d;
  logic [N-1:0]     table_q [DEPTH];
  logic             timer_load;
  logic             timer_match;
  logic             pulse;

  assign step_inc = step_q + IW'(1);
  assign pass_inc = pass_q + REP_W'(1);

  step_timer #(.N(N)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ena_i   (ena_i),
    .load_i  (timer_load),
    .ticks_i (cur_ticks_q),
    .match_o (timer_match)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    last_idx_d  = last_idx_q;
    pass_d      = pass_q;
    repeats_d   = repeats_q;
    cur_ticks_d = cur_ticks_q;
    done_d      = 1'b0;
    timer_load  = 1'b0;
    pulse       = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_load = 1'b1;
        if (start_i && !stop_i) begin
          state_d     = S_RUN;
          last_idx_d  = last_idx_i;
          repeats_d   = repeats_i;
          step_d      = '0;
          pass_d      = '0;
          cur_ticks_d = table_q[0];
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d    = S_IDLE;
          step_d     = '0;
          timer_load = 1'b1;
        end else if (ena_i && timer_match) begin
          pulse      = 1'b1;
          timer_load = 1'b1;
          if (step_q < last_idx_q) begin
            step_d      = step_inc;
            cur_ticks_d = table_q[step_inc];
          end else begin
            // Pass counter wraps silently when repeats is 0 (run forever).
            pass_d = pass_inc;
            step_d = '0;
            if ((repeats_q != '0) && (pass_inc == repeats_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              cur_ticks_d = table_q[0];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      last_idx_q  <= '0;
      pass_q      <= '0;
      repeats_q   <= '0;
      cur_ticks_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      last_idx_q  <= last_idx_d;
      pass_q      <= pass_d;
      repeats_q   <= repeats_d;
      cur_ticks_q <= cur_ticks_d;
      done_q      <= done_d;
    end
  end

  // Loads above read table_q, so a same-edge write to that entry is not seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      table_q[wr_addr_i] <= wr_ticks_i;
    end
  end

  assign busy_o  = (state_q == S_RUN);
  assign step_o  = step_q;
  assign pulse_o = pulse;
  assign done_o  = done_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: stimulus queues expected pulse/done
// events with absolute cycle numbers; a negedge monitor pops and compares.
module tb_pulse_sequencer;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int REP_W = 4;
  localparam int IW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [N-1:0]     wr_ticks;
  logic [IW-1:0]    last_idx;
  logic [REP_W-1:0] repeats;
  logic             start;
  logic             stop;
  logic             busy;
  logic [IW-1:0]    step;
  logic             pulse;
  logic             done;

  pulse_sequencer #(.N(N), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ena_i      (ena),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_ticks_i (wr_ticks),
    .last_idx_i (last_idx),
    .repeats_i  (repeats),
    .start_i    (start),
    .stop_i     (stop),
    .busy_o     (busy),
    .step_o     (step),
    .pulse_o    (pulse),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        is_done;
    logic [31:0] at;
    logic [31:0] stp;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  base   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Events are relative to the current run: cycle 1 is the first cycle after the start edge.
  task automatic expect_ev(input logic d, input int rel, input int stp);
    ev_t e;
    e.is_done = d;
    e.at      = 32'(base + rel - 1);
    e.stp     = 32'(stp);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic write_tab(input int addr, input int val);
    wr_en    = 1'b1;
    wr_addr  = IW'(addr);
    wr_ticks = N'(val);
    tick();
    wr_en    = 1'b0;
  endtask

  // Drives start for the coming edge and records where cycle 1 will be.
  task automatic do_start(input int li, input int rp);
    last_idx = IW'(li);
    repeats  = REP_W'(rp);
    start    = 1'b1;
    base     = cyc + 1;
  endtask

  task automatic expect_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic push_pattern_a();
    expect_ev(1'b0, 3, 0);
    expect_ev(1'b0, 4, 1);
    expect_ev(1'b0, 6, 2);
    expect_ev(1'b0, 9, 0);
    expect_ev(1'b0, 10, 1);
    expect_ev(1'b0, 12, 2);
    expect_ev(1'b1, 13, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && (pulse === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual pulse=%0b done=%0b step=%0d cyc=%0d expected none",
                 pulse, done, step, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind_done", 32'(done), 32'(mon_e.is_done));
        check("event_cycle", 32'(cyc), mon_e.at);
        check("event_step", 32'(step), mon_e.stp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; ena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_ticks = '0;
    last_idx = '0; repeats = '0; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_step", 32'(step), 32'd0);
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Table {3,1,2}, two passes, always enabled.
    write_tab(0, 3); write_tab(1, 1); write_tab(2, 2);
    do_start(2, 2);
    push_pattern_a();
    tick(); start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    run(12);
    check("busy_low_at_done", 32'(busy), 32'd0);
    run(3);
    expect_empty("pattern_a_events");

    // Same pattern with enable toggling; enabled cycles are the odd ones.
    do_start(2, 2);
    expect_ev(1'b0, 5, 0);
    expect_ev(1'b0, 7, 1);
    expect_ev(1'b0, 11, 2);
    expect_ev(1'b0, 17, 0);
    expect_ev(1'b0, 19, 1);
    expect_ev(1'b0, 23, 2);
    expect_ev(1'b1, 24, 0);
    tick(); start = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      ena = (k % 2 == 1);
      tick();
    end
    ena = 1'b1;
    expect_empty("ena_toggle_events");

    // Endless mode, period 2, stopped on a pulse cycle.
    write_tab(0, 2);
    do_start(0, 0);
    for (int k = 1; k <= 20; k++) expect_ev(1'b0, 2 * k, 0);
    tick(); start = 1'b0;
    run(41);
    stop = 1'b1;
    #1;
    check("no_pulse_on_stop", 32'(pulse), 32'd0);
    tick(); stop = 1'b0;
    check("idle_after_stop", 32'(busy), 32'd0);
    run(3);
    expect_empty("endless_events");

    // Writes while running: entry 1 written during its own step, entry 0
    // written on the same edge it is reloaded.
    write_tab(0, 2); write_tab(1, 2);
    do_start(1, 3);
    expect_ev(1'b0, 2, 0);
    expect_ev(1'b0, 4, 1);
    expect_ev(1'b0, 6, 0);
    expect_ev(1'b0, 11, 1);
    expect_ev(1'b0, 12, 0);
    expect_ev(1'b0, 17, 1);
    expect_ev(1'b1, 18, 0);
    tick(); start = 1'b0;
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 2'd1; wr_ticks = 8'd5;
    tick();
    wr_addr = 2'd0; wr_ticks = 8'd0;
    tick();
    wr_en = 1'b0;
    run(14);
    expect_empty("write_while_run_events");

    // start together with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle_busy", 32'(busy), 32'd0);
    run(2);

    // start while busy is ignored; start in the done cycle is accepted.
    write_tab(0, 3); write_tab(1, 1);
    do_start(2, 2);
    push_pattern_a();
    tick(); start = 1'b0;
    run(4);
    last_idx = 2'd0; repeats = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    run(7);
    check("done_high_in_done_cycle", 32'(done), 32'd1);
    do_start(0, 1);
    expect_ev(1'b0, 3, 0);
    expect_ev(1'b1, 4, 0);
    tick(); start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    run(5);
    expect_empty("restart_events");

    // Reset in the middle of a pulse cycle.
    write_tab(0, 3); write_tab(1, 1);
    do_start(1, 0);
    expect_ev(1'b0, 3, 0);
    tick(); start = 1'b0;
    run(3);
    check("pre_reset_pulse", 32'(pulse), 32'd1);
    check("pre_reset_step", 32'(step), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_step", 32'(step), 32'd0);
    check("midrun_reset_pulse", 32'(pulse), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    expect_empty("pre_reset_events");

    // Table is all zero after reset: every step lasts one cycle.
    do_start(3, 1);
    expect_ev(1'b0, 1, 0);
    expect_ev(1'b0, 2, 1);
    expect_ev(1'b0, 3, 2);
    expect_ev(1'b0, 4, 3);
    expect_ev(1'b1, 5, 0);
    tick(); start = 1'b0;
    run(6);
    expect_empty("cleared_table_events");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Programmable pulse-pattern controller for the etch-a-sketch timing path. It holds a small table of tick periods and plays them back in order. It emits a one-cycle `pulse` at the end of each step, and repeats the pattern for a programmed number of passes or indefinitely. Downstream blocks (cursor stepping, blink and sample strobes) use `pulse` instead of a fixed-period strobe, so one block sequences the timebase for all of them.

## Interface
- `N`, 8, width of a period entry and the step counter
- `DEPTH`, 4, number of table entries (power of two)
- `REP_W`, 4, width of the pass-count field
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `ena`  in  1  count enable; low freezes all counting state
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  $clog2(DEPTH)  table write index
- `wr_ticks`  in  N  period value written to `table[wr_addr]`
- `last_idx`  in  $clog2(DEPTH)  index of the final step in a pass; latched at start
- `repeats`  in  REP_W  passes to run; 0 = run until `stop`; latched at start
- `start`  in  1  begin a sequence; honoured only in IDLE
- `stop`  in  1  abort the sequence; honoured only in RUN
- `busy`  out  1  high while in RUN
- `step`  out  $clog2(DEPTH)  index of the current step (0 in IDLE)
- `pulse`  out  1  one-cycle strobe on the last enabled cycle of each step
- `done`  out  1  one-cycle strobe after the final pass completes

## Operation
- States: IDLE, RUN.
- IDLE → RUN on an edge with `start`=1 and `stop`=0. That edge latches `last_idx` and `repeats`, sets `step`=0 and `count`=1, clears `pass`, and loads `cur_ticks`=`table[0]`.
- In RUN with `ena`=1:
  - `pulse` = (`count` == `eff_ticks`) && !`stop`, where `eff_ticks` = (`cur_ticks`==0) ? 1 : `cur_ticks`. This is combinational from registered state and `stop`.
  - No pulse: `count` increments.
  - Pulse with `step` < latched `last_idx`: `step`+1, `count`=1, and `cur_ticks` is loaded from the new entry.
  - Pulse with `step` == `last_idx`: `pass`+1. If `repeats`≠0 and `pass`+1 == `repeats`, go to IDLE and assert `done` next cycle. Otherwise `step`=0, `count`=1, and `cur_ticks`=`table[0]`.
- In RUN with `ena`=0: `pulse`=0 and `count`, `step`, `pass` and state all hold.
- `stop` in RUN goes to IDLE at that edge, regardless of `ena`. No `pulse` and no `done` are produced.
- `start` in RUN is ignored. If `start` and `stop` are both high in IDLE, `start` is ignored.
- Table writes are accepted in any state and complete at the edge.
  - A running step uses its latched `cur_ticks`, so a write affects an entry only the next time that entry is loaded.
  - A load and a write to the same address at the same edge take the pre-write value.
- Width rules:
  - A step of period T lasts exactly max(T,1) enabled cycles. The maximum period is 2^N−1, and `count` never exceeds `eff_ticks`.
  - `pass` is REP_W bits. In `repeats`=0 mode it wraps silently.

## Timing
- Reset values (asynchronous): state=IDLE, `busy`=0, `step`=0, `pulse`=0, `done`=0, `count`=1, `pass`=0, all table entries 0.
- Reset mid-run aborts immediately, with no `done`.
- `busy` rises in the cycle after the accepting `start` edge and falls in the cycle after the final or `stop` edge.
- First `pulse` occurs max(`table[0]`,1) enabled cycles after the start edge.
- Pulses are exactly max(T,1) enabled cycles apart, with no gap between steps or between passes.
- `done` is registered and is high in the first IDLE cycle after the final pulse. A new `start` is accepted in that same cycle.

## Structure
- Package `pulse_seq_pkg`:
  - `typedef enum logic {S_IDLE, S_RUN} pulse_seq_state_t`
  - helper constant for index width
- Sub-module `step_timer`: `count` register, increment via `adder_n`, match via `comparator_eq`, plus the zero-as-one rule. Inputs are `ena`, `load` and `eff_ticks`; output is `match`.
- The FSM, the table (flop array, DEPTH×N) and pass logic live in the top level.

## Test plan
- Reset mid-run: assert `rst` during RUN → all outputs 0 in the same cycle, table reads 0, next `start` with empty table pulses every cycle.
- Table {3,1,2}, `last_idx`=2, `repeats`=2, `ena`=1 → pulses 3,4,6,9,10,12 cycles after start, `done` at cycle 13, `busy` low from cycle 13.
- Same setup with `ena` toggling 1/0 each cycle → each step spans 2× its cycles, no pulse while `ena`=0, same step order, single `done`.
- `repeats`=0, table {2}, `last_idx`=0 → pulse every 2 cycles for 40 cycles with no `done`. `stop` asserted on a pulse cycle → no pulse that cycle, IDLE next, no `done`.
- Write `table[1]`=5 while step 1 runs with `cur_ticks`=2 → current step still pulses at 2, next pass step 1 pulses at 5. Entry 0 written 0 → behaves as 1.
- `start`+`stop` together in IDLE → stays IDLE. `start` while busy → ignored, pattern unchanged. `start` in the `done` cycle → new run accepted.
